lif_neuron_array: RTL and testbench
===================================

LIF_NEURON_ARRAY -- requirements
Module: lif_neuron_array

Interface
REQ-001 Parameters SHALL be: N, default 4, neuron channel count (2..16); W, default 8, membrane/current width; RW, default 3, refractory counter width. CW = $clog2(N).
REQ-002 Ports SHALL be (name, direction, width, meaning):
- clk, in, 1, sole clock, rising edge.
- reset, in, 1, synchronous active-high reset.
- in_valid, in, 1, input current event valid.
- in_ready, out, 1, event accepted when in_valid && in_ready.
- in_chan, in, CW, target neuron.
- in_current, in, W, unsigned current to add.
- tick, in, 1, timestep strobe.
- cfg_threshold, in, W, firing threshold.
- cfg_leak_shift, in, 3, leak = u >> shift; 0 disables leak.
- cfg_refractory, in, RW, refractory ticks after a spike.
- cfg_reset_sub, in, 1, 1 = subtract threshold on spike; 0 = reset to zero.
- spikes, out, N, spike vector of the last completed timestep.
- spike_valid, out, 1, one-cycle pulse when spikes updates.
- busy, out, 1, timestep sweep in progress.
- overrun, out, 1, sticky: tick dropped while busy.
- dbg_chan, in, CW, membrane read select.
- dbg_mem, out, W, combinational membrane of dbg_chan.

Function
REQ-003 States SHALL be IDLE and SWEEP; IDLE->SWEEP on tick in IDLE; SWEEP->IDLE after channel N-1 updates.
REQ-004 in_ready SHALL equal !busy; events are accepted only in IDLE.
REQ-005 Accepted event SHALL add in_current to acc[in_chan], saturating at 2^W-1.
REQ-006 Config inputs SHALL be latched on the accepting tick cycle and held for the whole sweep.
REQ-007 For tick accepted in cycle T: busy high T+1..T+N; channel i updated in cycle T+1+i; spikes and spike_valid registered in cycle T+N+1.
REQ-008 Event accepted in the tick cycle T SHALL be included in that sweep.
REQ-009 Channel update: d = u - (u >> shift) (d = u when shift = 0); s = min(d + acc, 2^W-1) with W+1-bit intermediate; acc cleared.
REQ-010 If refractory count > 0: count decrements, u <= 0, acc discarded, no spike.
REQ-011 Else if s >= threshold: spike bit set; u <= s - threshold if cfg_reset_sub else 0; count <= cfg_refractory.
REQ-012 Else u <= s, spike bit clear.
REQ-013 spikes SHALL hold until the next sweep completes.
REQ-014 tick during SWEEP SHALL be ignored and set overrun; overrun clears only on reset.
REQ-015 Threshold 0 SHALL fire every non-refractory update.

Reset
REQ-016 reset SHALL force IDLE; membranes, accumulators, refractory counts, spikes, spike_valid, busy and overrun to 0; in_ready to 1 from the next cycle.
REQ-017 reset mid-sweep SHALL abort the sweep with no spike_valid pulse.
REQ-018 reset SHALL take priority over tick and in_valid in the same cycle.

Configuration
REQ-019 With macro LIF_REFRACTORY_EN defined, refractory counters and REQ-010 SHALL be implemented.
REQ-020 Without LIF_REFRACTORY_EN, no refractory state SHALL exist, cfg_refractory SHALL be ignored, and REQ-010 never applies; the port list is unchanged.

Verification
REQ-021 Reset: assert reset 2 cycles -> spikes=0, busy=0, overrun=0, in_ready=1, dbg_mem=0 all channels.
REQ-022 Integrate/fire: N=4, W=8, threshold 100, shift 0, reset_sub 1; event ch2 60, tick -> spikes=0000, mem[2]=60; event ch2 60, tick -> spikes=0100, mem[2]=20, spike_valid exactly at T+5.
REQ-023 Leak/reset-to-zero: mem[1]=80, shift 1, tick, no input -> mem[1]=40; then threshold 50, reset_sub 0, event ch1 30, tick -> spike bit1, mem[1]=0.
REQ-024 Saturation: three events ch0 200, threshold 255 -> acc 255, tick -> spikes[0]=1, mem[0]=0.
REQ-025 Refractory: refractory 2, ch3 fires, then event ch3 255 before each tick -> two ticks no spike, third tick spike (macro defined); macro undefined -> spike every tick.
REQ-026 Overrun: tick, tick again at T+2 -> overrun=1, in_ready=0 during busy, single spike_valid; reset at T+2 of a sweep -> no spike_valid, state zeroed.

Source files
------------

// File: rtl/lif_neuron_array.sv
// Array of leaky integrate-and-fire neurons, swept one channel per cycle.
// Optional refractory support: define LIF_REFRACTORY_EN.
module lif_neuron_array #(
  parameter  int N  = 4,
  parameter  int W  = 8,
  parameter  int RW = 3,
  localparam int CW = $clog2(N)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [CW-1:0] in_chan,
  input  logic [W-1:0]  in_current,
  input  logic          tick,
  input  logic [W-1:0]  cfg_threshold,
  input  logic [2:0]    cfg_leak_shift,
  input  logic [RW-1:0] cfg_refractory,
  input  logic          cfg_reset_sub,
  output logic [N-1:0]  spikes,
  output logic          spike_valid,
  output logic          busy,
  output logic          overrun,
  input  logic [CW-1:0] dbg_chan,
  output logic [W-1:0]  dbg_mem
);

  localparam logic [CW-1:0] LAST = CW'(N - 1);
  localparam logic [CW:0]   NCH  = (CW + 1)'(N);

  typedef enum logic {
    S_IDLE,
    S_SWEEP
  } state_t;

  state_t        r_state;
  state_t        w_next;
  logic [CW-1:0] r_idx;
  logic [W-1:0]  r_mem [N];
  logic [W-1:0]  r_acc [N];
  logic [W-1:0]  r_thr;
  logic [2:0]    r_shift;
  logic          r_rsub;
  logic [N-1:0]  r_work;
  logic [N-1:0]  r_spikes;
  logic          r_sv;
  logic          r_ovr;

  logic          w_sweep;
  logic          w_go;
  logic          w_last;
  logic          w_accept;
  logic [W:0]    w_acc_sum;
  logic [W-1:0]  w_acc_sat;
  logic [W-1:0]  w_u;
  logic [W-1:0]  w_a;
  logic [W-1:0]  w_d;
  logic [W:0]    w_sum;
  logic [W-1:0]  w_s;
  logic          w_refr;
  logic          w_fire;
  logic [W-1:0]  w_mem_nxt;
  logic [N-1:0]  w_work_nxt;

`ifdef LIF_REFRACTORY_EN
  logic [RW-1:0] r_ref [N];
  logic [RW-1:0] r_refc;
  assign w_refr = (r_ref[r_idx] != '0);
`else
  logic w_unused_refractory;
  assign w_unused_refractory = ^cfg_refractory;
  assign w_refr = 1'b0;
`endif

  assign w_sweep  = (r_state == S_SWEEP);
  assign w_go     = (r_state == S_IDLE) && tick;
  assign w_last   = (r_idx == LAST);
  assign in_ready = !w_sweep;
  assign busy     = w_sweep;
  assign spikes   = r_spikes;
  assign spike_valid = r_sv;
  assign overrun  = r_ovr;
  assign w_accept = in_valid && in_ready
                 && ({1'b0, in_chan} < NCH);
  assign dbg_mem  = ({1'b0, dbg_chan} < NCH)
                  ? r_mem[dbg_chan] : '0;

  // Saturating add of an incoming current event.
  always_comb begin
    w_acc_sum = {1'b0, r_acc[in_chan]}
              + {1'b0, in_current};
    w_acc_sat = w_acc_sum[W] ? '1 : w_acc_sum[W-1:0];
  end

  // Leak, integrate and fire for the channel under the sweep pointer.
  always_comb begin
    w_u = r_mem[r_idx];
    w_a = r_acc[r_idx];
    w_d = (r_shift == 3'd0) ? w_u
        : w_u - (w_u >> r_shift);
    w_sum = {1'b0, w_d} + {1'b0, w_a};
    w_s = w_sum[W] ? '1 : w_sum[W-1:0];
    w_fire = !w_refr && (w_s >= r_thr);
    w_mem_nxt = w_s;
    if (w_refr) begin
      w_mem_nxt = '0;
    end else if (w_fire) begin
      w_mem_nxt = r_rsub ? (w_s - r_thr) : '0;
    end
    w_work_nxt = r_work | (N'(w_fire) << r_idx);
  end

  // Next-state logic for the timestep sweep.
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:  if (tick) w_next = S_SWEEP;
      S_SWEEP: if (w_last) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  // Membranes, accumulators, latched config and spike outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < N; i++) begin
        r_mem[i] <= '0;
        r_acc[i] <= '0;
`ifdef LIF_REFRACTORY_EN
        r_ref[i] <= '0;
`endif
      end
`ifdef LIF_REFRACTORY_EN
      r_refc   <= '0;
`endif
      r_idx    <= '0;
      r_thr    <= '0;
      r_shift  <= '0;
      r_rsub   <= 1'b0;
      r_work   <= '0;
      r_spikes <= '0;
      r_sv     <= 1'b0;
      r_ovr    <= 1'b0;
    end else begin
      r_sv <= 1'b0;
      if (tick && w_sweep) r_ovr <= 1'b1;
      if (w_accept) r_acc[in_chan] <= w_acc_sat;
      if (w_go) begin
        r_thr   <= cfg_threshold;
        r_shift <= cfg_leak_shift;
        r_rsub  <= cfg_reset_sub;
`ifdef LIF_REFRACTORY_EN
        r_refc  <= cfg_refractory;
`endif
        r_idx   <= '0;
        r_work  <= '0;
      end
      if (w_sweep) begin
        r_mem[r_idx] <= w_mem_nxt;
        r_acc[r_idx] <= '0;
        r_work       <= w_work_nxt;
`ifdef LIF_REFRACTORY_EN
        if (w_refr)      r_ref[r_idx] <= r_ref[r_idx] - 1'b1;
        else if (w_fire) r_ref[r_idx] <= r_refc;
`endif
        if (w_last) begin
          r_spikes <= w_work_nxt;
          r_sv     <= 1'b1;
        end else begin
          r_idx <= r_idx + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_lif_neuron_array.sv
// Self-checking bench for lif_neuron_array (N=4, W=8).
// Expected spike vectors are queued at each tick and popped on spike_valid.
module tb_lif_neuron_array;

  localparam int N  = 4;
  localparam int W  = 8;
  localparam int RW = 3;
  localparam int CW = 2;

  logic          clk = 1'b0;
  logic          reset;
  logic          in_valid;
  logic          in_ready;
  logic [CW-1:0] in_chan;
  logic [W-1:0]  in_current;
  logic          tick;
  logic [W-1:0]  cfg_threshold;
  logic [2:0]    cfg_leak_shift;
  logic [RW-1:0] cfg_refractory;
  logic          cfg_reset_sub;
  logic [N-1:0]  spikes;
  logic          spike_valid;
  logic          busy;
  logic          overrun;
  logic [CW-1:0] dbg_chan;
  logic [W-1:0]  dbg_mem;

  int n_checks = 0;
  int n_fail   = 0;
  int n_sv     = 0;
  logic [N-1:0] exp_q [$];

  lif_neuron_array #(.N(N), .W(W), .RW(RW)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_chan(in_chan), .in_current(in_current),
    .tick(tick),
    .cfg_threshold(cfg_threshold),
    .cfg_leak_shift(cfg_leak_shift),
    .cfg_refractory(cfg_refractory),
    .cfg_reset_sub(cfg_reset_sub),
    .spikes(spikes), .spike_valid(spike_valid),
    .busy(busy), .overrun(overrun),
    .dbg_chan(dbg_chan), .dbg_mem(dbg_mem)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
  endtask

  task automatic send_event(input int ch, input int cur);
    in_valid   = 1'b1;
    in_chan    = CW'(ch);
    in_current = W'(cur);
    step();
    in_valid = 1'b0;
  endtask

  task automatic pulse_tick(input logic [N-1:0] e);
    exp_q.push_back(e);
    tick = 1'b1;
    step();
    tick = 1'b0;
  endtask

  task automatic peek(input int ch, output logic [W-1:0] v);
    dbg_chan = CW'(ch);
    @(negedge clk);
    v = dbg_mem;
    step();
  endtask

  task automatic set_cfg(input int thr, input int sh,
                         input int rf, input logic rs);
    cfg_threshold  = W'(thr);
    cfg_leak_shift = 3'(sh);
    cfg_refractory = RW'(rf);
    cfg_reset_sub  = rs;
  endtask

  // Entered in cycle T+1 of a sweep; lat is the cycle offset of spike_valid.
  task automatic sweep_wait(output int lat);
    logic [N-1:0] e;
    bit done;
    lat  = 0;
    done = 0;
    for (int c = 1; c <= 40 && !done; c++) begin
      @(negedge clk);
      if (spike_valid) begin
        n_sv++;
        if (lat == 0) lat = c;
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL sb_unexpected: spike_valid with spikes=%b, none expected",
                   spikes);
        end else begin
          e = exp_q.pop_front();
          if (spikes !== e) begin
            n_fail++;
            $display("FAIL sb_spikes: got %b expected %b", spikes, e);
          end
        end
      end
      if (c >= N + 3 && !busy) done = 1;
    end
    n_checks++;
    if (!done || exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL sb_drain: done=%0d pending=%0d expected done=1 pending=0",
               done, exp_q.size());
      exp_q.delete();
    end
    step();
  endtask

  task automatic test_reset();
    logic [W-1:0] v;
    set_cfg(100, 0, 0, 1'b1);
    do_reset();
    @(negedge clk);
    n_checks++;
    if (spikes !== '0 || busy !== 1'b0 || overrun !== 1'b0
        || in_ready !== 1'b1 || spike_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_outputs: spikes=%b busy=%b ovr=%b rdy=%b sv=%b expected 0,0,0,1,0",
               spikes, busy, overrun, in_ready, spike_valid);
    end
    step();
    for (int i = 0; i < N; i++) begin
      peek(i, v);
      n_checks++;
      if (v !== '0) begin
        n_fail++;
        $display("FAIL reset_mem%0d: got %0d expected 0", i, v);
      end
    end
  endtask

  task automatic test_integrate();
    logic [W-1:0] v;
    int lat;
    do_reset();
    set_cfg(100, 0, 0, 1'b1);
    send_event(2, 60);
    pulse_tick(4'b0000);
    sweep_wait(lat);
    peek(2, v);
    n_checks++;
    if (v !== 8'd60) begin
      n_fail++;
      $display("FAIL integ_mem2_a: got %0d expected 60", v);
    end
    send_event(2, 60);
    pulse_tick(4'b0100);
    n_checks++;
    if (busy !== 1'b1 || in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL integ_busy: busy=%b rdy=%b expected 1,0", busy, in_ready);
    end
    sweep_wait(lat);
    n_checks++;
    if (lat != N + 1) begin
      n_fail++;
      $display("FAIL integ_latency: got T+%0d expected T+%0d", lat, N + 1);
    end
    peek(2, v);
    n_checks++;
    if (v !== 8'd20) begin
      n_fail++;
      $display("FAIL integ_mem2_b: got %0d expected 20", v);
    end
    step();
    step();
    n_checks++;
    if (spikes !== 4'b0100) begin
      n_fail++;
      $display("FAIL integ_hold: got %b expected 0100", spikes);
    end
  endtask

  task automatic test_leak();
    logic [W-1:0] v;
    int lat;
    do_reset();
    set_cfg(100, 0, 0, 1'b1);
    send_event(1, 80);
    pulse_tick(4'b0000);
    sweep_wait(lat);
    set_cfg(100, 1, 0, 1'b1);
    pulse_tick(4'b0000);
    sweep_wait(lat);
    peek(1, v);
    n_checks++;
    if (v !== 8'd40) begin
      n_fail++;
      $display("FAIL leak_mem1: got %0d expected 40", v);
    end
    set_cfg(50, 1, 0, 1'b0);
    send_event(1, 30);
    pulse_tick(4'b0010);
    sweep_wait(lat);
    peek(1, v);
    n_checks++;
    if (v !== 8'd0) begin
      n_fail++;
      $display("FAIL leak_reset_zero: got %0d expected 0", v);
    end
  endtask

  task automatic test_saturation();
    logic [W-1:0] v;
    int lat;
    do_reset();
    set_cfg(255, 0, 0, 1'b0);
    send_event(0, 200);
    send_event(0, 200);
    send_event(0, 200);
    pulse_tick(4'b0001);
    sweep_wait(lat);
    peek(0, v);
    n_checks++;
    if (v !== 8'd0) begin
      n_fail++;
      $display("FAIL sat_mem0: got %0d expected 0", v);
    end
  endtask

  task automatic test_threshold_zero();
    int lat;
    do_reset();
    set_cfg(0, 0, 0, 1'b1);
    pulse_tick(4'b1111);
    sweep_wait(lat);
    pulse_tick(4'b1111);
    sweep_wait(lat);
  endtask

  task automatic test_refractory();
    logic [W-1:0] v;
    int lat;
    do_reset();
    set_cfg(100, 0, 2, 1'b0);
    send_event(3, 255);
    pulse_tick(4'b1000);
    sweep_wait(lat);
    for (int k = 0; k < 3; k++) begin
      send_event(3, 255);
`ifdef LIF_REFRACTORY_EN
      pulse_tick((k == 2) ? 4'b1000 : 4'b0000);
`else
      pulse_tick(4'b1000);
`endif
      sweep_wait(lat);
    end
    peek(3, v);
    n_checks++;
    if (v !== 8'd0) begin
      n_fail++;
      $display("FAIL refr_mem3: got %0d expected 0", v);
    end
  endtask

  task automatic test_overrun();
    logic [W-1:0] v;
    int lat;
    int sv0;
    do_reset();
    set_cfg(100, 0, 0, 1'b1);
    send_event(0, 150);
    sv0 = n_sv;
    pulse_tick(4'b0001);
    in_valid   = 1'b1;
    in_chan    = 2'd1;
    in_current = 8'd200;
    @(negedge clk);
    n_checks++;
    if (in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL ovr_ready: got %b expected 0", in_ready);
    end
    step();
    in_valid = 1'b0;
    tick = 1'b1;
    step();
    tick = 1'b0;
    sweep_wait(lat);
    n_checks++;
    if (overrun !== 1'b1 || n_sv - sv0 != 1) begin
      n_fail++;
      $display("FAIL ovr_flag: overrun=%b pulses=%0d expected 1,1",
               overrun, n_sv - sv0);
    end
    pulse_tick(4'b0000);
    sweep_wait(lat);
    n_checks++;
    if (overrun !== 1'b1) begin
      n_fail++;
      $display("FAIL ovr_sticky: got %b expected 1", overrun);
    end
  endtask

  task automatic test_reset_mid_sweep();
    logic [W-1:0] v;
    int pulses;
    send_event(0, 150);
    tick = 1'b1;
    step();
    tick = 1'b0;
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    pulses = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (spike_valid) pulses++;
    end
    step();
    n_checks++;
    if (pulses != 0 || busy !== 1'b0 || overrun !== 1'b0
        || spikes !== '0) begin
      n_fail++;
      $display("FAIL abort: pulses=%0d busy=%b ovr=%b spikes=%b expected 0,0,0,0",
               pulses, busy, overrun, spikes);
    end
    for (int i = 0; i < N; i++) begin
      peek(i, v);
      n_checks++;
      if (v !== '0) begin
        n_fail++;
        $display("FAIL abort_mem%0d: got %0d expected 0", i, v);
      end
    end
    reset    = 1'b1;
    tick     = 1'b1;
    in_valid = 1'b1;
    step();
    reset    = 1'b0;
    tick     = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    n_checks++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_priority: busy=%b expected 0", busy);
    end
    step();
  endtask

  initial begin
    reset      = 1'b1;
    in_valid   = 1'b0;
    in_chan    = '0;
    in_current = '0;
    tick       = 1'b0;
    dbg_chan   = '0;
    set_cfg(0, 0, 0, 1'b0);
    step();
    test_reset();
    test_integrate();
    test_leak();
    test_saturation();
    test_threshold_zero();
    test_refractory();
    test_overrun();
    test_reset_mid_sweep();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
